// File: rtl/bin_to_xs3_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_xs3_seq
// Description : Iterative double-dabble binary to packed BCD / excess-3
//               converter with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_xs3_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   dig_out,
    output logic                  busy
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int ACC_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] C_LAST_ITER = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_FIX  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit digits_fit();
        longint unsigned pow10;
        longint unsigned max_bin;
        pow10 = 64'd1;
        for (int i = 0; i < DIGITS; i++) begin
            if (pow10 < 64'h0100_0000_0000_0000) begin
                pow10 = pow10 * 64'd10;
            end
        end
        max_bin = (BIN_W >= 64) ? '1 : ((64'd1 << BIN_W) - 64'd1);
        return pow10 > max_bin;
    endfunction

    generate
        if (BIN_W < 4) begin : g_bad_bin_w
            $error("bin_to_xs3_seq: BIN_W must be at least 4");
        end
        if (!digits_fit()) begin : g_bad_digits
            $error("bin_to_xs3_seq: DIGITS too small for BIN_W");
        end
    endgenerate

    state_t             r_state;
    logic [BIN_W-1:0]   r_shift;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic [ACC_W-1:0]   r_dig;
    logic               r_out_valid;

    logic [ACC_W-1:0]   w_adj;
    logic [ACC_W-1:0]   w_xs3;

    generate
        for (genvar d = 0; d < DIGITS; d++) begin : g_digit
            assign w_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ? (r_acc[4*d +: 4] + 4'd3)
                                                                : r_acc[4*d +: 4];
            assign w_xs3[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_dig       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_shift <= bin_in;
                        r_mode  <= mode;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {r_acc, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt            <= r_cnt + 1'b1;
                    if (r_cnt == C_LAST_ITER) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_dig       <= r_mode ? w_xs3 : r_acc;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE) && rst_n;
    assign busy      = (r_state == ST_CONV) || (r_state == ST_FIX);
    assign out_valid = r_out_valid;
    assign dig_out   = r_dig;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_xs3_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_to_xs3_seq
// Description : Scoreboard bench for bin_to_xs3_seq (8-bit/3-digit and
//               4-bit/2-digit instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_xs3_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_a, in_ready_a, mode_a, out_valid_a, out_ready_a, busy_a;
    logic [7:0]  bin_a;
    logic [11:0] dig_a;
    logic        in_valid_b, in_ready_b, mode_b, out_valid_b, out_ready_b, busy_b;
    logic [3:0]  bin_b;
    logic [7:0]  dig_b;

    bin_to_xs3_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .bin_in(bin_a), .mode(mode_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .dig_out(dig_a), .busy(busy_a)
    );

    bin_to_xs3_seq #(.BIN_W(4), .DIGITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .bin_in(bin_b), .mode(mode_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .dig_out(dig_b), .busy(busy_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] exp_a[$];
    logic [7:0]  exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Decimal reference built from division, independent of shift-add-3.
    function automatic logic [15:0] ref_dec(input int v, input bit m, input int nd);
        logic [15:0] r;
        logic [3:0]  d;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            d = 4'(x % 10);
            if (m) d = d + 4'd3;
            r[4*i +: 4] = d;
            x = x / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            if (exp_a.size() == 0) report_fail("unexpected_out_a");
            else check("dig_a", 32'(dig_a), 32'(exp_a.pop_front()));
        end
        if (rst_n && out_valid_b && out_ready_b) begin
            if (exp_b.size() == 0) report_fail("unexpected_out_b");
            else check("dig_b", 32'(dig_b), 32'(exp_b.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready_a();
        int n = 0;
        while (!in_ready_a && n < 200) begin tick(); n++; end
        if (!in_ready_a) report_fail("in_ready_a_timeout");
    endtask

    task automatic send_a(input logic [7:0] v, input logic m, input logic [11:0] e, input bit push);
        wait_ready_a();
        if (push) exp_a.push_back(e);
        bin_a = v; mode_a = m; in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic send_timed_a(input logic [7:0] v, input logic m, input logic [11:0] e,
                                output int lat, output int bcnt);
        send_a(v, m, e, 1'b1);
        lat = 0; bcnt = 0;
        while (!out_valid_a && lat < 50) begin
            if (busy_a) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic send_b(input logic [3:0] v, input logic m, input logic [7:0] e);
        int n = 0;
        while (!in_ready_b && n < 200) begin tick(); n++; end
        if (!in_ready_b) report_fail("in_ready_b_timeout");
        exp_b.push_back(e);
        bin_b = v; mode_b = m; in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bcnt, n, seen;
        logic [15:0] r;

        rst_n = 1'b0;
        in_valid_a = 1'b0; bin_a = '0; mode_a = 1'b0; out_ready_a = 1'b1;
        in_valid_b = 1'b0; bin_b = '0; mode_b = 1'b0; out_ready_b = 1'b1;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_dig", 32'(dig_a), 32'h000);
        check("rst_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready_a), 32'd1);

        send_timed_a(8'hFF, 1'b0, 12'h255, lat, bcnt);
        check("latency_ff", 32'(lat), 32'd9);
        check("busy_cycles_ff", 32'(bcnt), 32'd9);
        send_a(8'hFF, 1'b1, 12'h588, 1'b1);

        send_a(8'd0,   1'b1, 12'h333, 1'b1);
        send_a(8'd9,   1'b1, 12'h33C, 1'b1);
        send_a(8'd10,  1'b1, 12'h343, 1'b1);
        send_a(8'd199, 1'b1, 12'h4CC, 1'b1);

        // Reset while idle clears the held result.
        wait_ready_a();
        check("hold_after_accept", 32'(dig_a), 32'h4CC);
        rst_n = 1'b0;
        tick(); tick();
        check("idle_rst_dig", 32'(dig_a), 32'h000);
        check("idle_rst_in_ready", 32'(in_ready_a), 32'd0);
        check("idle_rst_out_valid", 32'(out_valid_a), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_rel_in_ready", 32'(in_ready_a), 32'd1);

        // Backpressure with an ignored input pulse while holding.
        out_ready_a = 1'b0;
        send_a(8'hFF, 1'b1, 12'h588, 1'b1);
        n = 0;
        while (!out_valid_a && n < 50) begin tick(); n++; end
        if (!out_valid_a) report_fail("bp_out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 32'(out_valid_a), 32'd1);
            check("bp_dig", 32'(dig_a), 32'h588);
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
            if (i == 1) begin
                bin_a = 8'h42; mode_a = 1'b0; in_valid_a = 1'b1;
            end else begin
                in_valid_a = 1'b0;
            end
            tick();
        end
        in_valid_a = 1'b0;
        out_ready_a = 1'b1;
        tick();
        check("bp_release_out_valid", 32'(out_valid_a), 32'd0);
        check("bp_release_in_ready", 32'(in_ready_a), 32'd1);
        send_a(8'h42, 1'b0, 12'h066, 1'b1);

        // Abort on the fourth conversion cycle.
        send_a(8'd200, 1'b0, 12'h000, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        check("abort_out_valid", 32'(out_valid_a), 32'd0);
        check("abort_dig", 32'(dig_a), 32'h000);
        check("abort_busy", 32'(busy_a), 32'd0);
        rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            if (out_valid_a) seen++;
            tick();
        end
        check("abort_no_out_valid", 32'(seen), 32'd0);
        send_timed_a(8'd123, 1'b0, 12'h123, lat, bcnt);
        check("latency_123", 32'(lat), 32'd9);

        for (int v = 0; v < 256; v++) begin
            for (int m = 0; m < 2; m++) begin
                r = ref_dec(v, m[0], 3);
                send_a(8'(v), m[0], r[11:0], 1'b1);
            end
        end

        send_b(4'd9,  1'b1, 8'h3C);
        send_b(4'd15, 1'b1, 8'h48);
        for (int v = 0; v < 16; v++) begin
            r = ref_dec(v, 1'b1, 2);
            send_b(4'(v), 1'b1, r[7:0]);
        end

        n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 200) begin tick(); n++; end
        check("drain_a", 32'(exp_a.size()), 32'd0);
        check("drain_b", 32'(exp_b.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
